tpu_instr_issue: RTL
====================

// Module: tpu_instr_issue
// PURPOSE
// - Upstream issue stage of the TPU: buffers host instructions in a FIFO, screens opcodes, and drives the TPU's
//   32-bit instruction input. Each legal instruction is held stable for an opcode-dependent number of cycles,
//   followed by a one-cycle NOP bubble. Illegal opcodes are dropped and counted; the TPU never sees them.
// PARAMETERS
// - DEPTH      default 8  FIFO entries (power of 2, >=2)
// - HOLD_MMA   default 2  hold cycles for 0x03 WMMA_FP16 and 0x04 INT8_DP; 0x30 FUSED_MMA_RELU uses HOLD_MMA+1
// - HOLD_LONG  default 4  hold cycles for 0x20 CONV2D and 0x21 ATTENTION
// - HOLD_MEM   default 3  hold cycles for 0x10 DMA and 0x11 SCATTER_GATHER
// PORTS
// - clk          in   1              clock; all logic on the rising edge
// - rst          in   1              asynchronous, active-high reset
// - flush        in   1              synchronous: clears the FIFO and aborts the current hold
// - host_valid   in   1              host offers host_instr
// - host_instr   in   32             {opcode[31:24], regA[23:16], regB[15:12], regC[11:8], imm[7:0]}
// - host_ready   out  1              = !full; registered-state derived, not dependent on the same-cycle pop
// - instr_out    out  32             drives TPU instruction_in; 32'h0 (NOP) when not issuing
// - instr_valid  out  1              high while instr_out carries a legal held instruction
// - illegal_pulse out 1              one-cycle pulse when an illegal opcode is popped and dropped
// - illegal_count out 8              dropped-instruction count, saturates at 8'hFF
// - fifo_level   out  $clog2(DEPTH)+1  current occupancy
// - idle         out  1              FIFO empty and state IDLE
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE. instr_out=0, instr_valid=0, illegal_pulse=0, illegal_count=0,
//   fifo_level=0, host_ready=1, idle=1. Reset asserted mid-hold aborts immediately; no partial state survives.
// - Push: a word is written when host_valid && host_ready. Push and pop in the same cycle leave the level unchanged.
//   When full, host_ready=0 even if a pop occurs in that cycle. Pointers wrap modulo DEPTH.
// - Legal opcodes: {03,04,10,11,20,21,30}. All others, including 0x00, are illegal.
// - FSM has two states, IDLE and HOLD. All outputs are registered.
//   - IDLE, FIFO not empty: pop the head.
//     - Legal head: next cycle instr_out=head, instr_valid=1, cnt=hold(op)-1, state->HOLD.
//     - Illegal head: next cycle illegal_pulse=1, count+1 (saturating), state stays IDLE, instr_out stays 0.
//       Consecutive illegal heads are popped one per cycle.
//   - HOLD: instr_out/instr_valid held constant. While cnt!=0, cnt-1. When cnt==0, next cycle instr_out=0,
//     instr_valid=0, state->IDLE (the NOP bubble).
//   - No pop occurs during HOLD. Minimum spacing between two legal issues is therefore hold+1 cycles.
// - Latency: a word pushed into an empty FIFO in an IDLE cycle is popped the next cycle and appears on
//   instr_out the cycle after that (2 cycles from the push edge).
// - flush (highest priority after rst): on the next edge the FIFO is emptied, state->IDLE, instr_out=0,
//   instr_valid=0. illegal_count is kept. A push in the same cycle as flush is discarded.
// STRUCTURE
// - Package tpu_isa_pkg holds:
//   - opcode localparams (OP_WMMA=8'h03, OP_INT8_DP=8'h04, OP_DMA=8'h10, OP_SG=8'h11, OP_CONV2D=8'h20,
//     OP_ATTN=8'h21, OP_FUSED_MMA_RELU=8'h30, OP_NOP=8'h00);
//   - field bit positions;
//   - function is_legal(op).
//   Hold lengths are computed locally from the parameters.
// - Sub-module tpu_instr_fifo (DEPTH x 32 synchronous FIFO with level, full/empty, and a clear input).
//   tpu_instr_issue adds the FSM, the hold counter, and the illegal-opcode logic.
// TESTING
// - T1 reset: hold rst 2 cycles -> instr_out=0, instr_valid=0, host_ready=1, idle=1, illegal_count=0.
// - T2 single WMMA: push 32'h0301_2000 -> appears 2 cycles later for exactly 2 cycles, then 1 NOP cycle,
//   then idle=1.
// - T3 mixed stream: push 03,30,20,10 back-to-back -> valid runs of 2,3,4,3 cycles, each separated by
//   a single instr_out=0 cycle.
// - T4 illegal: push 32'h7F01_2000 then 32'h0401_2000 -> illegal_pulse for 1 cycle, count=1, and only
//   0x0401_2000 reaches instr_out.
// - T5 full/backpressure: push 9 words while holding a CONV2D -> host_ready=0 at level 8, the 9th word
//   is retained by the host, and no word is lost or duplicated.
// - T6 flush/reset mid-hold: flush during an ATTENTION hold -> next cycle instr_out=0 and level=0;
//   asynchronous rst mid-hold -> outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/tpu_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_isa_pkg
// Description : TPU instruction-set definitions shared by the issue stage.
//               Holds the opcode encodings, the bit positions of the
//               instruction fields, the issue FSM state type and the
//               legal-opcode screen.
//               Instruction word layout:
//               {opcode[31:24], regA[23:16], regB[15:12], regC[11:8], imm[7:0]}
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_isa_pkg;

    // Opcode encodings
    localparam logic [7:0] OP_NOP            = 8'h00;
    localparam logic [7:0] OP_WMMA           = 8'h03;
    localparam logic [7:0] OP_INT8_DP        = 8'h04;
    localparam logic [7:0] OP_DMA            = 8'h10;
    localparam logic [7:0] OP_SG             = 8'h11;
    localparam logic [7:0] OP_CONV2D         = 8'h20;
    localparam logic [7:0] OP_ATTN           = 8'h21;
    localparam logic [7:0] OP_FUSED_MMA_RELU = 8'h30;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 24;
    localparam int RA_MSB  = 23;
    localparam int RA_LSB  = 16;
    localparam int RB_MSB  = 15;
    localparam int RB_LSB  = 12;
    localparam int RC_MSB  = 11;
    localparam int RC_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Issue FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } issue_state_t;

    // Only the seven defined compute/memory opcodes may reach the TPU;
    // OP_NOP is deliberately rejected because the TPU treats 0 as a bubble.
    function automatic logic is_legal(input logic [7:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_WMMA, OP_INT8_DP, OP_DMA, OP_SG,
            OP_CONV2D, OP_ATTN, OP_FUSED_MMA_RELU: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tpu_instr_fifo
// Description : DEPTH x WIDTH synchronous FIFO with occupancy level,
//               full/empty flags and a synchronous clear. The head entry is
//               presented combinationally on rdata (first-word fall-through).
// Ports       : clk, rst (async, active-high)
//               clear  - synchronous empty, overrides push and pop
//               push   - write wdata (ignored when full)
//               pop    - discard head (ignored when empty)
//               rdata  - current head entry
//               level  - occupancy, 0..DEPTH
//               full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when a pop happens in the same cycle,
    // so the ready flag never depends on same-cycle consumption.
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tpu_instr_issue.sv
`default_nettype none
// ============================================================================
// Module      : tpu_instr_issue
// Description : Upstream issue stage of the TPU. Buffers host instructions,
//               screens opcodes and drives the TPU instruction input. A legal
//               instruction is held for an opcode-dependent number of cycles,
//               then followed by a single NOP bubble. Illegal opcodes are
//               dropped and counted (saturating).
// Ports       : clk, rst (async, active-high), flush (sync)
//               host_valid/host_instr/host_ready - host push handshake
//               instr_out/instr_valid            - TPU instruction input
//               illegal_pulse/illegal_count      - dropped-opcode reporting
//               fifo_level                       - buffer occupancy
//               idle                             - FIFO empty and FSM idle
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_instr_issue
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int HOLD_MMA  = 2,
    parameter int HOLD_LONG = 4,
    parameter int HOLD_MEM  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   host_valid,
    input  logic [31:0]            host_instr,
    output logic                   host_ready,
    output logic [31:0]            instr_out,
    output logic                   instr_valid,
    output logic                   illegal_pulse,
    output logic [7:0]             illegal_count,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   idle
);

    localparam int HOLD_FUSED = HOLD_MMA + 1;
    localparam int MAX_HOLD_A = (HOLD_FUSED > HOLD_LONG) ? HOLD_FUSED : HOLD_LONG;
    localparam int MAX_HOLD   = (MAX_HOLD_A > HOLD_MEM) ? MAX_HOLD_A : HOLD_MEM;
    // The counter only ever holds hold-1, so $clog2(MAX_HOLD) bits suffice.
    localparam int CNT_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    issue_state_t     state;
    logic [CNT_W-1:0] hold_cnt;
    logic [31:0]      fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       head_op;

    // Initial counter value (hold length minus one) for a legal opcode.
    function automatic logic [CNT_W-1:0] hold_init(input logic [7:0] op);
        logic [CNT_W-1:0] val;
        val = '0;
        case (op)
            OP_WMMA, OP_INT8_DP: val = CNT_W'(HOLD_MMA - 1);
            OP_FUSED_MMA_RELU:   val = CNT_W'(HOLD_FUSED - 1);
            OP_CONV2D, OP_ATTN:  val = CNT_W'(HOLD_LONG - 1);
            OP_DMA, OP_SG:       val = CNT_W'(HOLD_MEM - 1);
            default:             val = '0;
        endcase
        return val;
    endfunction

    assign head_op    = fifo_rdata[OP_MSB:OP_LSB];
    assign host_ready = !fifo_full;
    // A push coinciding with flush is discarded rather than surviving the clear.
    assign fifo_push  = host_valid && !fifo_full && !flush;
    // The head is consumed in every non-flushed IDLE cycle, legal or not.
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !flush;
    assign idle       = fifo_empty && (state == ST_IDLE);

    tpu_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (host_instr),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            instr_out     <= '0;
            instr_valid   <= 1'b0;
            illegal_pulse <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            // Abort any hold; the illegal count is deliberately preserved.
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            instr_out     <= '0;
            instr_valid   <= 1'b0;
            illegal_pulse <= 1'b0;
        end else begin
            illegal_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (is_legal(head_op)) begin
                            instr_out   <= fifo_rdata;
                            instr_valid <= 1'b1;
                            hold_cnt    <= hold_init(head_op);
                            state       <= ST_HOLD;
                        end else begin
                            illegal_pulse <= 1'b1;
                            if (illegal_count != 8'hFF) begin
                                illegal_count <= illegal_count + 8'd1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end else begin
                        // Leaving HOLD produces the one-cycle NOP bubble.
                        instr_out   <= '0;
                        instr_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
